uart_rx: RTL

UART receiver, the receive-side counterpart of the UART_TX path. Oversamples the serial line `RX_IN`, detects and qualifies the start bit, and deserializes `DATA_WIDTH` data bits LSB-first. It then optionally checks a parity bit, checks the stop bit, and presents the parallel word with a one-cycle `DATA_VALID` pulse or a one-cycle error flag. It sits between the pad-side serial input, already synchronized upstream, and the consumer logic clocked on `CLK`.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with start-bit qualification, optional parity and stop check.
// Optional build macro UART_RX_MAJORITY_EN selects 3-sample majority voting per bit.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
   logic                    smp_q, smp_d;
   logic                    pen_q, pen_d;
   logic                    ptyp_q, ptyp_d;
   logic                    perr_q, perr_d;
   logic                    valid_q, valid_d;
   logic                    perr_p_q, perr_p_d;
   logic                    serr_q, serr_d;
   logic                    smp_val;
   logic [CW-1:0]           smp_at;
   logic                    last;
`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;
   // Two-deep history of the line so the vote sees samples at mid-1, mid and mid+1.
   always_ff @(posedge CLK) begin
      if (RST) hist_q <= 2'b11;
      else     hist_q <= {hist_q[0], RX_IN};
   end
   assign smp_at  = CW'(OVERSAMPLE / 2 + 1);
   assign smp_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & RX_IN) | (hist_q[0] & RX_IN);
`else
   assign smp_at  = CW'(OVERSAMPLE / 2);
   assign smp_val = RX_IN;
`endif
   assign last       = cnt_q == LAST;
   assign P_DATA     = pdata_q;
   assign DATA_VALID = valid_q;
   assign PAR_ERR    = perr_p_q;
   assign STP_ERR    = serr_q;
   // State, counters, shift register and registered result pulses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         pdata_q  <= '0;
         smp_q    <= 1'b1;
         pen_q    <= 1'b0;
         ptyp_q   <= 1'b0;
         perr_q   <= 1'b0;
         valid_q  <= 1'b0;
         perr_p_q <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         pdata_q  <= pdata_d;
         smp_q    <= smp_d;
         pen_q    <= pen_d;
         ptyp_q   <= ptyp_d;
         perr_q   <= perr_d;
         valid_q  <= valid_d;
         perr_p_q <= perr_p_d;
         serr_q   <= serr_d;
      end
   end
   // Next-state logic: every decision is taken on the last oversample count of a bit.
   always_comb begin
      state_d  = state_q;
      cnt_d    = state_q == IDLE ? '0 : (last ? '0 : cnt_q + CW'(1));
      bit_d    = bit_q;
      data_d   = data_q;
      pdata_d  = pdata_q;
      smp_d    = cnt_q == smp_at ? smp_val : smp_q;
      pen_d    = pen_q;
      ptyp_d   = ptyp_q;
      perr_d   = perr_q;
      valid_d  = 1'b0;
      perr_p_d = 1'b0;
      serr_d   = 1'b0;
      case (state_q)
         IDLE: if (!RX_IN) begin
            state_d = START;
            cnt_d   = CW'(1);
            bit_d   = '0;
            pen_d   = PAR_EN;
            ptyp_d  = PAR_TYP;
            perr_d  = 1'b0;
         end
         START: if (last) state_d = smp_q ? IDLE : DATA;
         DATA: if (last) begin
            data_d  = {smp_q, data_q[DATA_WIDTH-1:1]};
            bit_d   = bit_q == LAST_BIT ? '0 : bit_q + BW'(1);
            state_d = bit_q != LAST_BIT ? DATA : (pen_q ? PARITY : STOP);
         end
         PARITY: if (last) begin
            perr_d  = smp_q != ((^data_q) ^ ptyp_q);
            state_d = STOP;
         end
         STOP: if (last) begin
            serr_d   = !smp_q;
            perr_p_d = smp_q & perr_q;
            valid_d  = smp_q & !perr_q;
            pdata_d  = smp_q & !perr_q ? data_q : pdata_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
